popcount_neuron_seq: RTL and testbench

// Sequencer that time-shares one external 32-input approximate popcount unit to evaluate a wide

---
 rtl/popcount_neuron_seq.sv | 123 ++++++++++++
 tb/tb_popcount_neuron_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_neuron_seq.sv
// popcount_neuron_seq: time-shares one 32-input popcount unit across NWORDS words to evaluate a wide neuron.
// Define TNN_SIGNED_EN for ternary weights (extra -1 weight pass, symmetric threshold).
module popcount_neuron_seq #(
  parameter int NWORDS = 4,
  parameter int PC_LAT = 2,
  parameter int ACC_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [NWORDS*32-1:0]   act_i,
  input  logic [NWORDS*32-1:0]   wpos_i,
  input  logic [NWORDS*32-1:0]   wneg_i,
  input  logic [ACC_W-1:0]       thr_i,
  output logic [31:0]            pc_op_o,
  input  logic [5:0]             pc_res_i,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ACC_W-1:0]       sum_o,
  output logic [1:0]             act_o
);
  localparam int WW = NWORDS > 1 ? $clog2(NWORDS) : 1;
  localparam int CW = PC_LAT > 1 ? $clog2(PC_LAT) : 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nx;
  logic [NWORDS*32-1:0] act_r, wpos_r;
  logic signed [ACC_W-1:0] acc, thr_r, thr_in;
  logic [WW-1:0] word, word_nx;
  logic [CW-1:0] wcnt;
  logic last_beat, last_word, finish, accept, sub;
  logic [31:0] op_nx;

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W-1:0] a,
                                                     input logic [5:0] r, input logic s_neg);
    logic signed [ACC_W:0] ext, s;
    ext = $signed({{(ACC_W-5){1'b0}}, r});
    s = s_neg ? $signed({a[ACC_W-1], a}) - ext : $signed({a[ACC_W-1], a}) + ext;
    return s[ACC_W] == s[ACC_W-1] ? s[ACC_W-1:0] : s[ACC_W] ? ACC_MIN : ACC_MAX;
  endfunction

  assign start_ready = state == IDLE;
  assign res_valid   = state == DONE;
  assign accept      = start_valid && start_ready;
  assign sum_o       = acc;
  assign last_beat   = wcnt == CW'(PC_LAT-1);
  assign last_word   = word == WW'(NWORDS-1);
  assign word_nx     = last_word ? '0 : word + 1'b1;

`ifdef TNN_SIGNED_EN
  logic [NWORDS*32-1:0] wneg_r;
  logic pass, pass_nx;
  assign pass_nx = last_word ? ~pass : pass;
  assign sub     = pass;
  assign finish  = last_beat && last_word && pass;
  assign thr_in  = thr_i[ACC_W-1] ? '0 : thr_i;
  assign op_nx   = act_r[word_nx*32 +: 32] &
                   (pass_nx ? wneg_r[word_nx*32 +: 32] : wpos_r[word_nx*32 +: 32]);
  assign act_o   = state != DONE ? 2'b00 : acc > thr_r ? 2'b01 : acc < -thr_r ? 2'b11 : 2'b00;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass   <= 1'b0;
      wneg_r <= '0;
    end else if (accept) begin
      pass   <= 1'b0;
      wneg_r <= wneg_i;
    end else if (state == RUN && last_beat) begin
      pass   <= pass_nx;
    end
  end
`else
  logic unused_wneg;
  assign unused_wneg = ^wneg_i;
  assign sub    = 1'b0;
  assign finish = last_beat && last_word;
  assign thr_in = thr_i;
  assign op_nx  = act_r[word_nx*32 +: 32] & wpos_r[word_nx*32 +: 32];
  assign act_o  = state == DONE && acc >= thr_r ? 2'b01 : 2'b00;
`endif

  always_comb begin
    state_nx = accept ? RUN :
               (state == RUN && finish) ? DONE :
               (state == DONE && res_ready) ? IDLE : state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end

  // The operand changes only on sampling beats so the slow unit sees it steady for PC_LAT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_r   <= '0;
      wpos_r  <= '0;
      thr_r   <= '0;
      acc     <= '0;
      word    <= '0;
      wcnt    <= '0;
      pc_op_o <= '0;
    end else if (accept) begin
      act_r   <= act_i;
      wpos_r  <= wpos_i;
      thr_r   <= thr_in;
      acc     <= '0;
      word    <= '0;
      wcnt    <= '0;
      pc_op_o <= act_i[31:0] & wpos_i[31:0];
    end else if (state == RUN) begin
      wcnt <= last_beat ? '0 : wcnt + 1'b1;
      if (last_beat) begin
        acc     <= sat_acc(acc, pc_res_i, sub);
        word    <= word_nx;
        pc_op_o <= finish ? '0 : op_nx;
      end
    end
  end
endmodule

// File: tb/tb_popcount_neuron_seq.sv
// tb_popcount_neuron_seq: randomized check of popcount_neuron_seq against a word-by-word arithmetic model,
// with a popcount unit that only returns a settled value after the operand has been held PC_LAT cycles.
module tb_popcount_neuron_seq;
  localparam int NW = 4, PL = 2, AW = 10, SW = 8;
`ifdef TNN_SIGNED_EN
  localparam int P = 2;
`else
  localparam int P = 1;
`endif

  logic clk = 0, rst_n = 1;
  always #5 clk = ~clk;

  logic start_valid = 0, start_ready, res_valid, res_ready = 0;
  logic [NW*32-1:0] act = '0, wpos = '0, wneg = '0;
  logic [AW-1:0] thr = '0, sum;
  logic [31:0] pc_op;
  logic [5:0] pc_res;
  logic [1:0] act_o;

  logic s_start_valid = 0, s_start_ready, s_res_valid, s_res_ready = 1;
  logic [SW-1:0] s_thr = '0, s_sum;
  logic [31:0] s_pc_op;
  logic [1:0] s_act;

  popcount_neuron_seq #(.NWORDS(NW), .PC_LAT(PL), .ACC_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .act_i(act), .wpos_i(wpos), .wneg_i(wneg), .thr_i(thr), .pc_op_o(pc_op), .pc_res_i(pc_res),
    .res_valid(res_valid), .res_ready(res_ready), .sum_o(sum), .act_o(act_o));

  popcount_neuron_seq #(.NWORDS(NW), .PC_LAT(1), .ACC_W(SW)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start_valid(s_start_valid), .start_ready(s_start_ready),
    .act_i(act), .wpos_i(wpos), .wneg_i(wneg), .thr_i(s_thr), .pc_op_o(s_pc_op), .pc_res_i(6'd63),
    .res_valid(s_res_valid), .res_ready(s_res_ready), .sum_o(s_sum), .act_o(s_act));

  int errors = 0, checks = 0;
  int mode = 0, age = 0;
  logic [31:0] last_op = '0;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int pc_f(input logic [31:0] op, input int m);
    int c;
    c = $countones(op);
    return m == 0 ? c : c + (op[0] ? 5 : 0);
  endfunction

  // Slow unit: garbage until the operand has been steady for PL cycles.
  always @(negedge clk) begin
    age <= (pc_op == last_op) ? age + 1 : 1;
    last_op <= pc_op;
  end
  always_comb pc_res = age >= PL ? 6'(pc_f(pc_op, mode)) : 6'(pc_f(pc_op, mode)) ^ 6'h2a;

  function automatic int clampi(input int v, input int w);
    int lo, hi;
    lo = -(1 << (w - 1));
    hi = (1 << (w - 1)) - 1;
    return v < lo ? lo : v > hi ? hi : v;
  endfunction

  function automatic logic [31:0] op_of(input logic [NW*32-1:0] a, wp, wn, input int idx);
    int p, k;
    p = idx / NW;
    k = idx % NW;
    return a[k*32 +: 32] & (p == 1 ? wn[k*32 +: 32] : wp[k*32 +: 32]);
  endfunction

  function automatic int ref_sum(input logic [NW*32-1:0] a, wp, wn, input int m, input int w, input bit c63);
    int s, r;
    s = 0;
    for (int i = 0; i < P * NW; i++) begin
      r = c63 ? 63 : pc_f(op_of(a, wp, wn, i), m);
      s = clampi(i >= NW ? s - r : s + r, w);
    end
    return s;
  endfunction

  function automatic logic [1:0] ref_act(input int s, input int t);
`ifdef TNN_SIGNED_EN
    int tc;
    tc = t < 0 ? 0 : t;
    return s > tc ? 2'b01 : s < -tc ? 2'b11 : 2'b00;
`else
    return s >= t ? 2'b01 : 2'b00;
`endif
  endfunction

  function automatic logic [NW*32-1:0] rnd_vec();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic do_req(input logic [NW*32-1:0] a, wp, wn, input int t, input int hold, input string tag);
    int exp_s, lat;
    logic [1:0] exp_a;
    exp_s = ref_sum(a, wp, wn, mode, AW, 0);
    exp_a = ref_act(exp_s, t);
    @(negedge clk);
    act = a; wpos = wp; wneg = wn; thr = AW'(t); start_valid = 1;
    check({tag, ":start_ready"}, start_ready, 1);
    @(posedge clk);
    #1 start_valid = 0;
    thr = ~thr;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      if (res_valid) break;
      check({tag, ":pc_op"}, pc_op, op_of(a, wp, wn, lat / PL));
      lat++;
    end
    check({tag, ":latency"}, lat, P * NW * PL);
    check({tag, ":sum"}, $signed(sum), exp_s);
    check({tag, ":act"}, act_o, exp_a);
    check({tag, ":done_op"}, pc_op, 0);
    check({tag, ":done_ready"}, start_ready, 0);
    repeat (hold) begin
      @(negedge clk);
      start_valid = 1'($urandom);
      act = rnd_vec();
      check({tag, ":hold_valid"}, res_valid, 1);
      check({tag, ":hold_ready"}, start_ready, 0);
      check({tag, ":hold_sum"}, $signed(sum), exp_s);
      check({tag, ":hold_act"}, act_o, exp_a);
    end
    @(negedge clk);
    start_valid = 0; res_ready = 1;
    @(posedge clk);
    #1 res_ready = 0;
    check({tag, ":post_valid"}, res_valid, 0);
    check({tag, ":post_ready"}, start_ready, 1);
  endtask

  initial begin
    logic [NW*32-1:0] a, wp, wn, ones;
    int s, t, lat, cyc;
    int times[$];
    ones = '1;
    #2 rst_n = 0;
    #1;
    check("rst:start_ready", start_ready, 1);
    check("rst:res_valid", res_valid, 0);
    check("rst:pc_op", pc_op, 0);
    check("rst:sum", sum, 0);
    check("rst:act", act_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    do_req(ones, ones, '0, 100, 0, "t1");
    wp = '0; wp[15:0] = 16'hFFFF;
    wn = '0; wn[63:32] = 32'hFFFF_FFFF;
    do_req(ones, wp, wn, 5, 0, "t2");
    do_req(rnd_vec(), rnd_vec(), rnd_vec(), 3, 10, "bp");

    for (int i = 0; i < 12; i++) begin
      mode = i % 2;
      a = (i % 4 == 3) ? ones : rnd_vec();
      wp = rnd_vec();
      wn = (i % 3 == 0) ? rnd_vec() & rnd_vec() : rnd_vec();
      s = ref_sum(a, wp, wn, mode, AW, 0);
      t = (i % 5 == 4) ? -int'($urandom_range(0, 20)) : (s < 0 ? -s : s) + int'($urandom_range(0, 4)) - 2;
      do_req(a, wp, wn, t, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    mode = 0;
    @(negedge clk);
    act = rnd_vec(); wpos = rnd_vec(); wneg = rnd_vec(); thr = 10; start_valid = 1;
    @(posedge clk);
    #1 start_valid = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    check("mid_rst:pc_op", pc_op, 0);
    check("mid_rst:res_valid", res_valid, 0);
    check("mid_rst:start_ready", start_ready, 1);
    check("mid_rst:sum", sum, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (8) begin
      @(negedge clk);
      check("mid_rst:idle", res_valid, 0);
    end
    do_req(ones, ones, ones, 50, 1, "after_rst");

    s = ref_sum(ones, ones, ones, 0, SW, 1);
    @(negedge clk);
    act = ones; wpos = ones; wneg = ones; s_thr = 8'd127; s_start_valid = 1;
    @(posedge clk);
    #1 s_start_valid = 0;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      if (s_res_valid) break;
      lat++;
    end
    check("sat:latency", lat, P * NW);
    check("sat:sum", $signed(s_sum), s);
    check("sat:act", s_act, ref_act(s, 127));
    check("sat:op", s_pc_op, 0);

    @(negedge clk);
    s_thr = 8'd20; s_start_valid = 1;
    cyc = 0;
    while (cyc < 80 && times.size() < 4) begin
      @(negedge clk);
      if (s_res_valid) begin
        times.push_back(cyc);
        check("b2b:sum", $signed(s_sum), s);
        check("b2b:ready", s_start_ready, 0);
      end
      cyc++;
    end
    s_start_valid = 0;
    check("b2b:count", times.size(), 4);
    for (int i = 1; i < times.size(); i++) check("b2b:period", times[i] - times[i-1], P * NW + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
